lv_fv_pattern_gen: RTL and testbench

//  Synthetic video source driving the lv_fv_data stream (R,G,B,FV,LV,DV).

---
 rtl/lv_fv_pattern_pkg.sv | 50 +++++
 rtl/lv_fv_pattern_gen_if.sv | 25 ++
 rtl/lv_fv_pattern_pix.sv | 26 ++
 rtl/lv_fv_pattern_gen.sv | 191 +++++++++++++++++++
 tb/tb_lv_fv_pattern_gen.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lv_fv_pattern_pkg.sv
// Shared types for the lv_fv_data pattern generator: FSM states, pattern
// selection codes and the colour-bar lookup.
package lv_fv_pattern_pkg;

    typedef logic [23:0] rgb_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_F_PRE   = 3'd1,
        ST_ACT     = 3'd2,
        ST_H_BLANK = 3'd3,
        ST_F_POST  = 3'd4,
        ST_V_BLANK = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PAT_SOLID   = 2'd0,
        PAT_BARS    = 2'd1,
        PAT_RAMP    = 2'd2,
        PAT_CHECKER = 2'd3
    } pat_e;

    localparam int NUM_BARS = 8;

    // Bars run left to right from white down to black.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lv_fv_pattern_gen_if.sv
// lv_fv_data video stream plus the generator's run/pattern controls.
interface lv_fv_pattern_gen_if;

    logic        en;
    logic [1:0]  pat_sel;
    logic [7:0]  R;
    logic [7:0]  G;
    logic [7:0]  B;
    logic        FV;
    logic        LV;
    logic        DV;
    logic [15:0] frame_cnt;
    logic        frame_done;

    modport master (
        input  en, pat_sel,
        output R, G, B, FV, LV, DV, frame_cnt, frame_done
    );

    modport slave (
        output en, pat_sel,
        input  R, G, B, FV, LV, DV, frame_cnt, frame_done
    );

endinterface

// File: rtl/lv_fv_pattern_pix.sv
// Combinational pixel colour for the active pixel at (x, y); the caller
// registers the result.
module lv_fv_pattern_pix
    import lv_fv_pattern_pkg::*;
#(
    parameter rgb_t SOLID = 24'hFF0000
) (
    input  pat_e       pat_i,
    input  logic [7:0] x_i,
    input  logic       y4_i,
    input  logic [2:0] bar_idx_i,
    output rgb_t       rgb_o
);

    always_comb begin
        rgb_o = '0;
        case (pat_i)
            PAT_SOLID:   rgb_o = SOLID;
            PAT_BARS:    rgb_o = bar_colour(bar_idx_i);
            PAT_RAMP:    rgb_o = {x_i, x_i, x_i};
            PAT_CHECKER: rgb_o = (x_i[4] ^ y4_i) ? 24'hFFFFFF : 24'h000000;
            default:     rgb_o = '0;
        endcase
    end

endmodule

// File: rtl/lv_fv_pattern_gen.sv
// Synthetic lv_fv_data source: frame/line timing FSM with programmable
// active size and blanking, active pixels filled from a latched test pattern.
module lv_fv_pattern_gen
    import lv_fv_pattern_pkg::*;
#(
    parameter int   ACT_W   = 640,
    parameter int   ACT_H   = 480,
    parameter int   FV_PRE  = 4,
    parameter int   H_BLANK = 16,
    parameter int   FV_POST = 4,
    parameter int   V_BLANK = 32,
    parameter rgb_t SOLID   = 24'hFF0000
) (
    input  logic                clk,
    input  logic                rst,
    lv_fv_pattern_gen_if.master vid
);

    localparam int XW   = $clog2(ACT_W);
    localparam int YW   = (ACT_H > 1) ? $clog2(ACT_H) : 1;
    localparam int BPB  = ACT_W / NUM_BARS;
    localparam int BW   = (BPB > 1) ? $clog2(BPB) : 1;
    localparam int MAXB = max4(FV_PRE, H_BLANK, FV_POST, V_BLANK);
    localparam int CW   = $clog2(MAXB + 1);

    localparam logic [XW-1:0] X_LAST   = XW'(ACT_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(ACT_H - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BPB - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(FV_PRE - 1);
    localparam logic [CW-1:0] HBL_LAST = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] PST_LAST = CW'(FV_POST - 1);
    localparam logic [CW-1:0] VBL_LAST = CW'(V_BLANK - 1);

    state_e        state_q;
    pat_e          pat_q;
    logic [CW-1:0] cnt_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [BW-1:0] bar_cnt_q;
    logic [2:0]    bar_idx_q;
    logic [15:0]   frame_cnt_q;

    rgb_t          rgb_q;
    logic          fv_q;
    logic          lv_q;
    logic          dv_q;
    logic          frame_done_q;

    rgb_t          pix_d;
    logic [7:0]    pix_x;
    logic          pix_y4;

    assign pix_x = 8'(x_q);

    generate
        if (YW > 4) begin : g_y4
            assign pix_y4 = y_q[4];
        end else begin : g_no_y4
            assign pix_y4 = 1'b0;
        end
    endgenerate

    lv_fv_pattern_pix #(
        .SOLID (SOLID)
    ) u_pix (
        .pat_i     (pat_q),
        .x_i       (pix_x),
        .y4_i      (pix_y4),
        .bar_idx_i (bar_idx_q),
        .rgb_o     (pix_d)
    );

    // Outputs are a registered image of the current state, so the stream
    // trails the FSM by one cycle (en seen at edge k -> FV from edge k+1).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pat_q        <= PAT_SOLID;
            cnt_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            bar_cnt_q    <= '0;
            bar_idx_q    <= '0;
            frame_cnt_q  <= '0;
            rgb_q        <= '0;
            fv_q         <= 1'b0;
            lv_q         <= 1'b0;
            dv_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            fv_q         <= (state_q != ST_IDLE) && (state_q != ST_V_BLANK);
            lv_q         <= (state_q == ST_ACT);
            dv_q         <= (state_q == ST_ACT);
            rgb_q        <= (state_q == ST_ACT) ? pix_d : '0;
            frame_done_q <= (state_q == ST_V_BLANK) && (cnt_q == VBL_LAST);

            case (state_q)
                ST_IDLE: begin
                    if (vid.en) begin
                        state_q     <= ST_F_PRE;
                        cnt_q       <= '0;
                        pat_q       <= pat_e'(vid.pat_sel);
                        frame_cnt_q <= frame_cnt_q + 1'b1;
                    end
                end

                ST_F_PRE: begin
                    if (cnt_q == PRE_LAST) begin
                        state_q   <= ST_ACT;
                        cnt_q     <= '0;
                        x_q       <= '0;
                        y_q       <= '0;
                        bar_cnt_q <= '0;
                        bar_idx_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_ACT: begin
                    if (x_q == X_LAST) begin
                        x_q       <= '0;
                        bar_cnt_q <= '0;
                        bar_idx_q <= '0;
                        cnt_q     <= '0;
                        state_q   <= (y_q == Y_LAST) ? ST_F_POST : ST_H_BLANK;
                    end else begin
                        x_q <= x_q + 1'b1;
                        // Bar index advances every ACT_W/8 pixels without a divider.
                        if (bar_cnt_q == BAR_LAST) begin
                            bar_cnt_q <= '0;
                            bar_idx_q <= bar_idx_q + 1'b1;
                        end else begin
                            bar_cnt_q <= bar_cnt_q + 1'b1;
                        end
                    end
                end

                ST_H_BLANK: begin
                    if (cnt_q == HBL_LAST) begin
                        state_q <= ST_ACT;
                        cnt_q   <= '0;
                        y_q     <= y_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_F_POST: begin
                    if (cnt_q == PST_LAST) begin
                        state_q <= ST_V_BLANK;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_V_BLANK: begin
                    if (cnt_q == VBL_LAST) begin
                        cnt_q <= '0;
                        // en is only honoured here, so a frame is never cut short.
                        if (vid.en) begin
                            state_q     <= ST_F_PRE;
                            pat_q       <= pat_e'(vid.pat_sel);
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign vid.R          = rgb_q[23:16];
    assign vid.G          = rgb_q[15:8];
    assign vid.B          = rgb_q[7:0];
    assign vid.FV         = fv_q;
    assign vid.LV         = lv_q;
    assign vid.DV         = dv_q;
    assign vid.frame_cnt  = frame_cnt_q;
    assign vid.frame_done = frame_done_q;

endmodule

// File: tb/tb_lv_fv_pattern_gen.sv
// Scoreboard bench for lv_fv_pattern_gen on a 16x4 frame: stimulus queues
// expected frames/pixels, a negedge monitor pops and compares.
module tb_lv_fv_pattern_gen;

    localparam int ACT_W   = 16;
    localparam int ACT_H   = 4;
    localparam int FV_PRE  = 2;
    localparam int H_BLANK = 3;
    localparam int FV_POST = 2;
    localparam int V_BLANK = 5;

    localparam int FV_LEN       = 77;
    localparam int PERIOD       = 82;
    localparam int DV_PER_FRAME = 64;

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    typedef struct {
        int cnt;
        bit b2b;
    } frame_rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lv_fv_pattern_gen_if vid();

    lv_fv_pattern_gen #(
        .ACT_W   (ACT_W),
        .ACT_H   (ACT_H),
        .FV_PRE  (FV_PRE),
        .H_BLANK (H_BLANK),
        .FV_POST (FV_POST),
        .V_BLANK (V_BLANK),
        .SOLID   (24'hFF0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vid (vid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [23:0] exp_pix [$];
    frame_rec_t  exp_frm [$];
    bit          mon_en   = 1'b0;
    int          done_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [23:0] model(input int pat, input int x, input int y);
        logic [7:0] xb;
        logic [4:0] xv;
        logic [4:0] yv;
        xb = 8'(x);
        xv = 5'(x);
        yv = 5'(y);
        case (pat)
            0:       return 24'hFF0000;
            1:       return BARS[x / 2];
            2:       return {xb, xb, xb};
            default: return (xv[4] ^ yv[4]) ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    task automatic push_frame(input int pat, input int cnt, input bit b2b);
        frame_rec_t r;
        r.cnt = cnt;
        r.b2b = b2b;
        exp_frm.push_back(r);
        for (int y = 0; y < ACT_H; y++)
            for (int x = 0; x < ACT_W; x++)
                exp_pix.push_back(model(pat, x, y));
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return vid.FV;
            1:       return vid.LV;
            default: return vid.frame_done;
        endcase
    endfunction

    // Waits, bounded, for a rising edge of FV (0), LV (1) or frame_done (2).
    task automatic wait_edge(input int which, input int max_cyc, input string nm);
        logic prev;
        logic cur;
        bit   seen;
        seen = 1'b0;
        prev = sig(which);
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            cur = sig(which);
            if (cur && !prev) seen = 1'b1;
            prev = cur;
        end
        chk(nm, seen, 1);
    endtask

    // Monitor
    int          cyc        = 0;
    int          fv_len     = 0;
    int          lv_len     = 0;
    int          lv_bursts  = 0;
    int          dv_cnt     = 0;
    int          since_fall = 1000;
    int          last_rise  = -1;
    int          period     = 0;
    logic        prev_fv    = 1'b0;
    logic        prev_lv    = 1'b0;
    logic [15:0] rise_cnt   = '0;

    always @(negedge clk) begin
        logic [23:0] rgb;
        logic [23:0] ep;
        frame_rec_t  rec;
        cyc++;
        if (!mon_en) begin
            prev_fv   = 1'b0;
            prev_lv   = 1'b0;
            last_rise = -1;
        end else begin
            rgb = {vid.R, vid.G, vid.B};
            if (vid.FV && !prev_fv) begin
                fv_len    = 0;
                lv_bursts = 0;
                dv_cnt    = 0;
                rise_cnt  = vid.frame_cnt;
                if (last_rise >= 0) period = cyc - last_rise;
                last_rise = cyc;
            end
            if (vid.FV) fv_len++;
            chk("dv_eq_lv", vid.DV, vid.LV);
            if (vid.LV && !prev_lv) begin
                lv_bursts++;
                lv_len = 0;
            end
            if (vid.LV) lv_len++;
            if (!vid.LV && prev_lv) chk("lv_burst_len", lv_len, ACT_W);
            if (vid.DV) begin
                dv_cnt++;
                chk("pix_queue_nonempty", exp_pix.size() != 0, 1);
                if (exp_pix.size() != 0) begin
                    ep = exp_pix.pop_front();
                    chk("pixel_rgb", rgb, ep);
                end
            end else begin
                chk("rgb_blank", rgb, 0);
            end
            if (!vid.FV && prev_fv) begin
                since_fall = 0;
                chk("frame_queue_nonempty", exp_frm.size() != 0, 1);
                if (exp_frm.size() != 0) begin
                    rec = exp_frm.pop_front();
                    chk("fv_len", fv_len, FV_LEN);
                    chk("lv_bursts", lv_bursts, ACT_H);
                    chk("dv_count", dv_cnt, DV_PER_FRAME);
                    chk("frame_cnt", rise_cnt, rec.cnt);
                    if (rec.b2b) chk("frame_period", period, PERIOD);
                end
            end else begin
                since_fall++;
            end
            if (vid.frame_done) begin
                done_cnt++;
                chk("done_pos", since_fall, V_BLANK - 1);
                chk("done_fv_low", vid.FV, 0);
            end
            prev_fv = vid.FV;
            prev_lv = vid.LV;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        vid.en      = 1'b0;
        vid.pat_sel = 2'd0;
        rst         = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_fv", vid.FV, 0);
        chk("rst_lv", vid.LV, 0);
        chk("rst_dv", vid.DV, 0);
        chk("rst_r", vid.R, 0);
        chk("rst_g", vid.G, 0);
        chk("rst_b", vid.B, 0);
        chk("rst_done", vid.frame_done, 0);
        chk("rst_frame_cnt", vid.frame_cnt, 0);

        rst = 1'b0;
        push_frame(0, 1, 1'b0);
        mon_en = 1'b1;
        vid.en = 1'b1;

        wait_edge(0, 20, "f1_start");
        push_frame(0, 2, 1'b1);
        wait_edge(0, 100, "f2_start");
        vid.pat_sel = 2'd1;
        push_frame(1, 3, 1'b1);
        wait_edge(0, 100, "f3_start");
        vid.pat_sel = 2'd2;
        push_frame(2, 4, 1'b1);
        wait_edge(0, 100, "f4_start");
        vid.pat_sel = 2'd3;
        push_frame(3, 5, 1'b1);
        wait_edge(0, 100, "f5_start");
        vid.pat_sel = 2'd0;
        push_frame(0, 6, 1'b1);
        wait_edge(0, 100, "f6_start");
        wait_edge(1, 10, "f6_line0");
        wait_edge(1, 30, "f6_line1");
        vid.en = 1'b0;
        wait_edge(2, 100, "f6_done");
        repeat (20) @(negedge clk);

        chk("idle_fv", vid.FV, 0);
        chk("idle_lv", vid.LV, 0);
        chk("idle_dv", vid.DV, 0);
        chk("idle_rgb", {vid.R, vid.G, vid.B}, 0);
        chk("idle_frame_cnt", vid.frame_cnt, 6);
        chk("idle_done_count", done_cnt, 6);
        chk("idle_pix_left", exp_pix.size(), 0);
        chk("idle_frm_left", exp_frm.size(), 0);

        mon_en      = 1'b0;
        vid.pat_sel = 2'd2;
        vid.en      = 1'b1;
        wait_edge(1, 30, "rst_run_lv");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_fv", vid.FV, 0);
        chk("midrst_lv", vid.LV, 0);
        chk("midrst_dv", vid.DV, 0);
        chk("midrst_rgb", {vid.R, vid.G, vid.B}, 0);
        chk("midrst_frame_cnt", vid.frame_cnt, 0);

        rst    = 1'b0;
        vid.en = 1'b0;
        repeat (3) @(negedge clk);
        chk("postrst_fv", vid.FV, 0);

        push_frame(2, 1, 1'b0);
        mon_en = 1'b1;
        vid.en = 1'b1;
        @(negedge clk);
        chk("restart_fv_lat", vid.FV, 0);
        chk("restart_cnt", vid.frame_cnt, 1);
        @(negedge clk);
        chk("restart_fv", vid.FV, 1);
        vid.en = 1'b0;
        wait_edge(2, 150, "restart_done");
        repeat (10) @(negedge clk);

        chk("end_fv", vid.FV, 0);
        chk("end_frame_cnt", vid.frame_cnt, 1);
        chk("end_done_count", done_cnt, 7);
        chk("end_pix_left", exp_pix.size(), 0);
        chk("end_frm_left", exp_frm.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
